odd_parity_serial_checker: RTL and testbench
============================================

Name: odd_parity_serial_checker

Overview:
Receive-side companion to the team's odd-parity generator. Deserialises one frame per transfer: start bit, DATA_W data bits LSB-first, one odd-parity bit, stop bit. Reassembles the data word, checks odd parity over data plus parity bit, and checks the stop bit. Sits between a serial link bit-sampler (one qualified bit per in_valid) and the parallel consumer.

Parameters:
DATA_W, 4, data bits per frame (1..16)
CNT_W, 8, width of the optional error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
sin  input  1  serial line bit; idle level 1
in_valid  input  1  sin is a valid sampled bit this cycle
data_out  output  DATA_W  last received data word
data_valid  output  1  one-cycle pulse: frame complete, data_out/flags updated
parity_err  output  1  last frame failed odd parity; qualified by data_valid, held until next frame
frame_err  output  1  last frame had stop bit 0; qualified by data_valid, held until next frame
busy  output  1  high in any state except IDLE
err_count  output  CNT_W  error counter (see Optional Feature)

Behaviour:
- One clock domain; reset asynchronous active-low; all outputs registered.
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0, state=IDLE, bit counter=0, shift register=0.
- A bit is consumed only on a rising edge with in_valid=1. in_valid=0 freezes state, counter and shift register. Gaps of any length are legal in any state.
- FSM:
  - IDLE: sin=0 -> DATA, counter=0. sin=1 -> stay.
  - DATA: shift sin in LSB-first; counter++. After the DATA_W-th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: on accept, update data_out; set parity_err = NOT(XOR of data bits and parity bit); set frame_err = NOT sin; pulse data_valid; -> IDLE.
- Odd parity: total count of ones over data plus parity bit must be odd. Example: 4'b1011 needs parity 0; 4'b0000 needs parity 1.
- Latency: data_valid is high for exactly the one cycle after the edge that accepts the stop bit.
- data_valid pulses for every completed frame, including frames with errors.
- A frame with a bad stop bit is still delivered with frame_err=1. No resynchronisation beyond returning to IDLE.
- Back-to-back frames: a start bit may be accepted on the edge immediately after the stop bit. data_valid of the previous frame overlaps that cycle with no loss.
- Reset mid-frame: the partial frame is discarded and no data_valid is produced. data_out and the flags return to 0.
- busy=1 from the edge accepting the start bit until the edge accepting the stop bit.

Optional Feature:
Macro ODD_PARITY_ERR_CNT_EN.
- Defined:
  - err_count increments by 1 on each completed frame with parity_err or frame_err set.
  - A frame with both errors counts once.
  - The counter saturates at 2^CNT_W-1 and is cleared only by reset.
- Undefined:
  - The counter logic is absent and err_count is tied to 0.
  - Port list is unchanged.

Test Plan:
1. DATA_W=4. Stream sin 0,1,1,0,1,0,1 with in_valid=1 every cycle. Required: data_valid one cycle with data_out=4'hB, parity_err=0, frame_err=0.
2. Same frame but parity bit 1 (0,1,1,0,1,1,1). Required: data_out=4'hB, parity_err=1. With the macro defined, err_count goes 0->1.
3. Data 4'h0 with parity 1 and stop 0 (0,0,0,0,0,1,0). Required: data_out=4'h0, parity_err=0, frame_err=1, data_valid still pulses.
4. Frame for 4'h5 with in_valid deasserted for 3 cycles between every bit. Required: data_out=4'h5, parity_err=0, exactly one data_valid pulse, busy high throughout.
5. Assert rst_n=0 after the 2nd data bit, release, then send a clean 4'hC frame. Required: no data_valid for the aborted frame, all outputs 0 during reset, then data_out=4'hC with flags clear.
6. Two frames back-to-back (4'h3 then 4'hE, no idle bits). Required: two data_valid pulses 7 cycles apart, carrying 4'h3 then 4'hE.

Source files
------------

// File: rtl/odd_parity_serial_checker.sv
// Serial odd-parity frame receiver: start, DATA_W data bits LSB-first, parity, stop.
// Define ODD_PARITY_ERR_CNT_EN to build the saturating errored-frame counter.
module odd_parity_serial_checker #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  localparam int CW = (DATA_W < 2) ? 1 : $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              accept_stop;

  assign accept_stop = in_valid && (state == STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      unique case (state)
        IDLE:    if (!sin) state_nxt = DATA;
        DATA:    if (cnt == LAST) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Each data bit lands at its own index, so no stale bits survive between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      busy       <= (state_nxt != IDLE);
      if (in_valid) begin
        unique case (state)
          IDLE: cnt <= '0;
          DATA: begin
            shreg[cnt] <= sin;
            cnt        <= cnt + CW'(1);
          end
          PARITY: par_bit <= sin;
          STOP: begin
            data_out   <= shreg;
            parity_err <= ~(^{shreg, par_bit});
            frame_err  <= ~sin;
            data_valid <= 1'b1;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

`ifdef ODD_PARITY_ERR_CNT_EN
  logic frame_bad;
  assign frame_bad = ~(^{shreg, par_bit}) | ~sin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (accept_stop && frame_bad && (err_count != {CNT_W{1'b1}}))
      err_count <= err_count + CNT_W'(1);
  end
`else
  logic unused_accept;
  assign unused_accept = accept_stop;
  assign err_count     = '0;
`endif

endmodule

// File: tb/tb_odd_parity_serial_checker.sv
// Directed bench for odd_parity_serial_checker (DATA_W=4): clean, bad parity,
// bad stop, gapped, reset-abort and back-to-back frames.
module tb_odd_parity_serial_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int exp_cnt = 0;
  logic [3:0] dv_data [$];
  int         dv_cyc  [$];

  odd_parity_serial_checker #(.DATA_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .in_valid(in_valid),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cnt++;
      dv_data.push_back(data_out);
      dv_cyc.push_back(cyc);
    end
  end

  // Drives one frame; inputs change 1 time unit after the rising edge.
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s,
                            input int gap, input bit chk_busy);
    logic [6:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 7; i++) begin
      sin = bits[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sin = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        if (chk_busy && i < 6) begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_gap bit%0d: got %b want 1", i, busy);
          end
        end
      end
    end
    sin = 1'b1;
  endtask

  task automatic check_frame(input string nm, input int dv0, input logic [3:0] d,
                             input logic pe, input logic fe);
    @(posedge clk); #1;
    checks++;
    if (dv_cnt - dv0 !== 1) begin
      errors++;
      $display("FAIL %s_pulses: got %0d want 1", nm, dv_cnt - dv0);
    end
    checks++;
    if ({data_out, parity_err, frame_err, data_valid, busy} !== {d, pe, fe, 2'b00}) begin
      errors++;
      $display("FAIL %s_out: got d=%h pe=%b fe=%b dv=%b busy=%b want d=%h pe=%b fe=%b dv=0 busy=0",
               nm, data_out, parity_err, frame_err, data_valid, busy, d, pe, fe);
    end
    checks++;
    if (err_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL %s_errcnt: got %0d want %0d", nm, err_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({data_out, data_valid, parity_err, frame_err, busy, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: got d=%h dv=%b pe=%b fe=%b busy=%b cnt=%0d want all 0",
               data_out, data_valid, parity_err, frame_err, busy, err_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    int dv0 = dv_cnt;
    send_frame(4'hB, 1'b0, 1'b1, 0, 1'b0);
    check_frame("clean", dv0, 4'hB, 1'b0, 1'b0);
  endtask

  task automatic test_parity_err();
    int dv0 = dv_cnt;
    send_frame(4'hB, 1'b1, 1'b1, 0, 1'b0);
`ifdef ODD_PARITY_ERR_CNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    check_frame("parity", dv0, 4'hB, 1'b1, 1'b0);
  endtask

  task automatic test_frame_err();
    int dv0 = dv_cnt;
    send_frame(4'h0, 1'b1, 1'b0, 0, 1'b0);
`ifdef ODD_PARITY_ERR_CNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    check_frame("stopbit", dv0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_gaps();
    int dv0 = dv_cnt;
    send_frame(4'h5, 1'b1, 1'b1, 3, 1'b1);
    check_frame("gaps", dv0, 4'h5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int dv0 = dv_cnt;
    for (int i = 0; i < 3; i++) begin
      sin = (i == 0) ? 1'b0 : 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #3;
    checks++;
    if ({data_out, data_valid, parity_err, frame_err, busy, err_count} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got d=%h dv=%b pe=%b fe=%b busy=%b cnt=%0d want all 0",
               data_out, data_valid, parity_err, frame_err, busy, err_count);
    end
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dv_cnt !== dv0) begin
      errors++;
      $display("FAIL midframe_no_dv: got %0d pulses want 0", dv_cnt - dv0);
    end
    dv0 = dv_cnt;
    send_frame(4'hC, 1'b1, 1'b1, 0, 1'b0);
    check_frame("after_reset", dv0, 4'hC, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n0 = dv_data.size();
    send_frame(4'h3, 1'b1, 1'b1, 0, 1'b0);
    send_frame(4'hE, 1'b0, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (dv_data.size() - n0 !== 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d want 2", dv_data.size() - n0);
    end else begin
      checks++;
      if (dv_data[n0] !== 4'h3 || dv_data[n0+1] !== 4'hE) begin
        errors++;
        $display("FAIL b2b_data: got %h,%h want 3,e", dv_data[n0], dv_data[n0+1]);
      end
      checks++;
      if (dv_cyc[n0+1] - dv_cyc[n0] !== 7) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d want 7", dv_cyc[n0+1] - dv_cyc[n0]);
      end
    end
    checks++;
    if ({parity_err, frame_err, busy} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_flags: got pe=%b fe=%b busy=%b want 000", parity_err, frame_err, busy);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_parity_err();
    test_frame_err();
    test_gaps();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
